// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c command sequencer: command word layout,
// direction encoding, FSM states and the SCL divider helper.
package i2c_pkg;

  localparam int unsigned DEV_ADDR_LSB  = 49;
  localparam int unsigned DEV_ADDR_W    = 7;
  localparam int unsigned RW_BIT        = 48;
  localparam int unsigned DATA_ADDR_LSB = 32;
  localparam int unsigned DATA_ADDR_W   = 16;
  localparam int unsigned WDATA_LSB     = 24;
  localparam int unsigned WDATA_W       = 8;
  localparam int unsigned CTRL_LSB      = 16;
  localparam int unsigned CTRL_W        = 8;
  localparam int unsigned DIV_LSB       = 0;
  localparam int unsigned DIV_W         = 16;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RESP,
    S_GAP,
    S_DONE
  } seq_state_e;

  // SCL divider field value for a given system clock and bus rate
  function automatic logic [DIV_W-1:0] calc_divider(input int unsigned clk_freq_mhz,
                                                    input int unsigned scl_khz);
    return DIV_W'((clk_freq_mhz * 1000) / scl_khz);
  endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Command/response bus between the sequencer and the i2c master's command FIFO.
interface i2c_cmd_sequencer_if #(
  parameter int unsigned CMD_WIDTH = 56
);

  logic [CMD_WIDTH-1:0] i2c_fifo_din;
  logic                 i2c_fifo_wr_en;
  logic                 i2c_fifo_full;
  logic                 i2c_wr_data_success;
  logic [7:0]           i2c_rdata;
  logic                 i2c_rdata_valid;

  modport master (
    output i2c_fifo_din,
    output i2c_fifo_wr_en,
    input  i2c_fifo_full,
    input  i2c_wr_data_success,
    input  i2c_rdata,
    input  i2c_rdata_valid
  );

  modport slave (
    input  i2c_fifo_din,
    input  i2c_fifo_wr_en,
    output i2c_fifo_full,
    output i2c_wr_data_success,
    output i2c_rdata,
    output i2c_rdata_valid
  );

endinterface

// File: rtl/i2c_cmd_table.sv
// Single-port-style command table: synchronous write, registered read with
// enable so the read word holds until the next fetch.
module i2c_cmd_table #(
  parameter int unsigned NUM_CMDS  = 16,
  parameter int unsigned CMD_WIDTH = 56
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_CMDS)-1:0] wr_addr,
  input  logic [CMD_WIDTH-1:0]        wr_data,
  input  logic                        rd_en,
  input  logic [$clog2(NUM_CMDS)-1:0] rd_addr,
  output logic [CMD_WIDTH-1:0]        rd_data
);

  logic [CMD_WIDTH-1:0] mem [NUM_CMDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; table contents survive reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Runtime-programmable command player for the i2c master command FIFO:
// issues one table entry at a time, waits for completion or timeout, reports reads.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_CMDS            = 16,
  parameter int unsigned CMD_WIDTH           = 56,
  parameter int unsigned RESP_TIMEOUT_CYCLES = 100000,
  parameter int unsigned INTER_CMD_GAP       = 0,
  parameter int unsigned CNT_WIDTH           = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop_en,
  input  logic [$clog2(NUM_CMDS):0]   num_cmds,
  input  logic                        tbl_wr_en,
  input  logic [$clog2(NUM_CMDS)-1:0] tbl_wr_addr,
  input  logic [CMD_WIDTH-1:0]        tbl_wr_data,
  i2c_cmd_sequencer_if.master         bus,
  output logic [7:0]                  rd_result,
  output logic [$clog2(NUM_CMDS)-1:0] rd_result_idx,
  output logic                        rd_result_valid,
  output logic                        timeout_pulse,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_CMDS)-1:0] cmd_idx,
  output logic [CNT_WIDTH-1:0]        pass_cnt,
  output logic [CNT_WIDTH-1:0]        timeout_cnt
);

  localparam int unsigned IDX_W      = $clog2(NUM_CMDS);
  localparam int unsigned NC_W       = IDX_W + 1;
  localparam int unsigned TIMER_W    = $clog2(RESP_TIMEOUT_CYCLES + 1);
  localparam int unsigned TIMER_LAST = RESP_TIMEOUT_CYCLES - 1;
  localparam int unsigned GAP_W      = (INTER_CMD_GAP > 1) ? $clog2(INTER_CMD_GAP) : 1;
  localparam int unsigned GAP_LAST   = (INTER_CMD_GAP > 0) ? INTER_CMD_GAP - 1 : 0;

  seq_state_e           state_q, state_d;
  logic [NC_W-1:0]      count_q, count_d;
  logic [IDX_W-1:0]     cmd_idx_d;
  logic [CNT_WIDTH-1:0] pass_d, timeout_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [7:0]           rd_result_d;
  logic [IDX_W-1:0]     rd_idx_d;
  logic                 rd_valid_d, timeout_d_pulse;
  logic                 fifo_wr_en_c, tbl_rd_en_c;
  logic                 resp_hit_c, last_c, end_cmd_c, advance_c;
  logic [CMD_WIDTH-1:0] tbl_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  i2c_cmd_table #(
    .NUM_CMDS  (NUM_CMDS),
    .CMD_WIDTH (CMD_WIDTH)
  ) u_table (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (tbl_wr_en && (state_q == S_IDLE)),
    .wr_addr (tbl_wr_addr),
    .wr_data (tbl_wr_data),
    .rd_en   (tbl_rd_en_c),
    .rd_addr (cmd_idx),
    .rd_data (tbl_q)
  );

  // The table read register is held outside FETCH, so din stays stable through ISSUE/WAIT
  assign bus.i2c_fifo_din   = tbl_q;
  assign bus.i2c_fifo_wr_en = fifo_wr_en_c;

  assign resp_hit_c = (bus.i2c_fifo_din[RW_BIT] == RD) ? bus.i2c_rdata_valid
                                                       : bus.i2c_wr_data_success;
  assign last_c     = ({1'b0, cmd_idx} == (count_q - NC_W'(1)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    cmd_idx_d       = cmd_idx;
    pass_d          = pass_cnt;
    timeout_d       = timeout_cnt;
    timer_d         = timer_q;
    gap_d           = gap_q;
    stop_pend_d     = stop_pend_q | (stop && (state_q != S_IDLE));
    rd_result_d     = rd_result;
    rd_idx_d        = rd_result_idx;
    rd_valid_d      = 1'b0;
    timeout_d_pulse = 1'b0;
    fifo_wr_en_c    = 1'b0;
    tbl_rd_en_c     = 1'b0;
    end_cmd_c       = 1'b0;
    advance_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (num_cmds != '0)) begin
          count_d   = (num_cmds > NC_W'(NUM_CMDS)) ? NC_W'(NUM_CMDS) : num_cmds;
          cmd_idx_d = '0;
          pass_d    = '0;
          timeout_d = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        tbl_rd_en_c = 1'b1;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        if (!bus.i2c_fifo_full) begin
          fifo_wr_en_c = 1'b1;
          timer_d      = '0;
          state_d      = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        // A response landing on the expiry cycle still counts as a completion
        if (resp_hit_c) begin
          pass_d    = sat_inc(pass_cnt);
          end_cmd_c = 1'b1;
          if (bus.i2c_fifo_din[RW_BIT] == RD) begin
            rd_result_d = bus.i2c_rdata;
            rd_idx_d    = cmd_idx;
            rd_valid_d  = 1'b1;
          end
        end else if (timer_q == TIMER_W'(TIMER_LAST)) begin
          timeout_d       = sat_inc(timeout_cnt);
          timeout_d_pulse = 1'b1;
          end_cmd_c       = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
        if (end_cmd_c) begin
          if (INTER_CMD_GAP > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            advance_c = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          advance_c = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Next-command decision shared by the WAIT_RESP and GAP exits
    if (advance_c) begin
      if (stop_pend_d) begin
        state_d = S_IDLE;
      end else if (last_c) begin
        if (loop_en) begin
          cmd_idx_d = '0;
          state_d   = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end else begin
        cmd_idx_d = cmd_idx + IDX_W'(1);
        state_d   = S_FETCH;
      end
    end

    if (state_d == S_IDLE) begin
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q         <= '0;
      cmd_idx         <= '0;
      pass_cnt        <= '0;
      timeout_cnt     <= '0;
      timer_q         <= '0;
      gap_q           <= '0;
      stop_pend_q     <= 1'b0;
      rd_result       <= '0;
      rd_result_idx   <= '0;
      rd_result_valid <= 1'b0;
      timeout_pulse   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      count_q         <= count_d;
      cmd_idx         <= cmd_idx_d;
      pass_cnt        <= pass_d;
      timeout_cnt     <= timeout_d;
      timer_q         <= timer_d;
      gap_q           <= gap_d;
      stop_pend_q     <= stop_pend_d;
      rd_result       <= rd_result_d;
      rd_result_idx   <= rd_idx_d;
      rd_result_valid <= rd_valid_d;
      timeout_pulse   <= timeout_d_pulse;
      busy            <= (state_d != S_IDLE);
      done            <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: table-driven sequence plus
// hand-written corner cases, with a responding i2c master model and scoreboard queues.
module tb_i2c_cmd_sequencer;
  import i2c_pkg::*;

  localparam int unsigned N_CMDS  = 16;
  localparam int unsigned T_OUT   = 1000;
  localparam int unsigned CW      = 56;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, stop, loop_en;
  logic [4:0]  num_cmds;
  logic        tbl_wr_en;
  logic [3:0]  tbl_wr_addr;
  logic [CW-1:0] tbl_wr_data;
  logic [7:0]  rd_result;
  logic [3:0]  rd_result_idx;
  logic        rd_result_valid, timeout_pulse, busy, done;
  logic [3:0]  cmd_idx;
  logic [15:0] pass_cnt, timeout_cnt;

  i2c_cmd_sequencer_if #(.CMD_WIDTH(CW)) bus ();

  i2c_cmd_sequencer #(
    .NUM_CMDS            (N_CMDS),
    .CMD_WIDTH           (CW),
    .RESP_TIMEOUT_CYCLES (T_OUT),
    .INTER_CMD_GAP       (0),
    .CNT_WIDTH           (16)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .stop            (stop),
    .loop_en         (loop_en),
    .num_cmds        (num_cmds),
    .tbl_wr_en       (tbl_wr_en),
    .tbl_wr_addr     (tbl_wr_addr),
    .tbl_wr_data     (tbl_wr_data),
    .bus             (bus),
    .rd_result       (rd_result),
    .rd_result_idx   (rd_result_idx),
    .rd_result_valid (rd_result_valid),
    .timeout_pulse   (timeout_pulse),
    .busy            (busy),
    .done            (done),
    .cmd_idx         (cmd_idx),
    .pass_cnt        (pass_cnt),
    .timeout_cnt     (timeout_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
  } rd_exp_t;

  typedef struct {
    logic       rw;
    logic [15:0] daddr;
    logic [7:0] wdata;
    logic       exp_rd;
    logic [7:0] exp_data;
  } vec_t;

  logic [CW-1:0] exp_cmd_q [$];
  rd_exp_t       exp_rd_q  [$];

  int n_total = 0;
  int n_pass  = 0;

  // Model controls (written by the test) and observations (written by the model)
  int resp_delay = 10;
  int skip_at    = -1;
  int stray_req  = 0;
  int n_writes = 0, n_resp = 0, n_done = 0, n_tp = 0;
  int tp_cyc = 0, enter_cyc = 0, stray_done = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [CW-1:0] mk_cmd(input logic rw, input logic [15:0] daddr,
                                           input logic [7:0] wdata);
    return {7'h50, rw, daddr, wdata, 8'h00, calc_divider(100, 400)};
  endfunction

  // i2c master model + output monitor, all sampled on the falling edge
  initial begin : model
    logic [7:0]    mem [256];
    logic [CW-1:0] word;
    logic          pend, pend_rd;
    logic [7:0]    pend_addr;
    int            fire;
    rd_exp_t       e;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    pend = 1'b0; pend_rd = 1'b0; pend_addr = 8'h00; fire = 0;
    bus.i2c_rdata = 8'h00;
    bus.i2c_rdata_valid = 1'b0;
    bus.i2c_wr_data_success = 1'b0;
    forever begin
      @(negedge clk);
      bus.i2c_rdata_valid = 1'b0;
      bus.i2c_wr_data_success = 1'b0;
      if (!rstn) begin
        pend = 1'b0;
      end else begin
        if (bus.i2c_fifo_wr_en) begin
          word = bus.i2c_fifo_din;
          if (exp_cmd_q.size() == 0) check("fifo_wr_unexpected", 64'(1), 64'(0));
          else check("fifo_din", 64'(word), 64'(exp_cmd_q.pop_front()));
          if (word[RW_BIT] == WR) mem[word[DATA_ADDR_LSB +: 8]] = word[WDATA_LSB +: 8];
          if (n_writes != skip_at) begin
            pend = 1'b1; pend_rd = word[RW_BIT];
            pend_addr = word[DATA_ADDR_LSB +: 8];
            fire = cyc + resp_delay;
          end else begin
            enter_cyc = cyc + 1;
          end
          n_writes++;
        end
        if (pend && cyc == fire) begin
          if (pend_rd == RD) begin
            bus.i2c_rdata = mem[pend_addr];
            bus.i2c_rdata_valid = 1'b1;
          end else begin
            bus.i2c_wr_data_success = 1'b1;
          end
          pend = 1'b0;
          n_resp++;
        end
        if (stray_req != stray_done) begin
          bus.i2c_rdata = 8'h5A;
          bus.i2c_rdata_valid = 1'b1;
          stray_done++;
        end
        if (rd_result_valid) begin
          if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_rd_q.pop_front();
            check("rd_result_idx", 64'(rd_result_idx), 64'(e.idx));
            check("rd_result", 64'(rd_result), 64'(e.data));
          end
        end
        if (timeout_pulse) begin n_tp++; tp_cyc = cyc; end
        if (done) n_done++;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tbl_write(input int addr, input logic [CW-1:0] data);
    step();
    tbl_wr_en = 1'b1; tbl_wr_addr = 4'(addr); tbl_wr_data = data;
    step();
    tbl_wr_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    step();
    start = 1'b1; num_cmds = 5'(n);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin @(negedge clk); k++; end while (busy && k < budget);
    check("idle_reached", 64'(busy), 64'(0));
  endtask

  initial begin : test
    vec_t          vecs [5];
    logic [CW-1:0] words [5];
    int base, r0, d0, tp0, k;

    rstn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; num_cmds = '0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    bus.i2c_fifo_full = 1'b0;

    vecs[0] = '{WR, 16'h0000, 8'hAA, 1'b0, 8'h00};
    vecs[1] = '{WR, 16'h0001, 8'hAB, 1'b0, 8'h00};
    vecs[2] = '{WR, 16'h0002, 8'hAC, 1'b0, 8'h00};
    vecs[3] = '{WR, 16'h0003, 8'hAD, 1'b0, 8'h00};
    vecs[4] = '{RD, 16'h0000, 8'h00, 1'b1, 8'hAA};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_wr_en", 64'(bus.i2c_fifo_wr_en), 64'(0));
    check("rst_pass_cnt", 64'(pass_cnt), 64'(0));
    check("rst_timeout_cnt", 64'(timeout_cnt), 64'(0));
    check("rst_cmd_idx", 64'(cmd_idx), 64'(0));
    check("rst_rd_valid", 64'(rd_result_valid), 64'(0));

    // Table-driven sequence: four EEPROM writes then a read-back of address 0
    for (int i = 0; i < 5; i++) begin
      words[i] = mk_cmd(vecs[i].rw, vecs[i].daddr, vecs[i].wdata);
      tbl_write(i, words[i]);
      exp_cmd_q.push_back(words[i]);
      if (vecs[i].exp_rd) exp_rd_q.push_back('{idx: 4'(i), data: vecs[i].exp_data});
    end
    resp_delay = 50; base = n_writes; d0 = n_done;
    do_start(5);
    wait_idle(2000);
    check("t1_writes", 64'(n_writes - base), 64'(5));
    check("t1_pass_cnt", 64'(pass_cnt), 64'(5));
    check("t1_timeout_cnt", 64'(timeout_cnt), 64'(0));
    check("t1_done", 64'(n_done - d0), 64'(1));
    check("t1_cmd_idx", 64'(cmd_idx), 64'(4));
    check("t1_cmd_q_empty", 64'(exp_cmd_q.size()), 64'(0));
    check("t1_rd_q_empty", 64'(exp_rd_q.size()), 64'(0));

    // FIFO full held across FETCH/ISSUE
    resp_delay = 10; base = n_writes;
    exp_cmd_q.push_back(words[0]);
    step();
    bus.i2c_fifo_full = 1'b1;
    do_start(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t2_wr_en_while_full", 64'(bus.i2c_fifo_wr_en), 64'(0));
      if (i >= 1) check("t2_din_stable", 64'(bus.i2c_fifo_din), 64'(words[0]));
    end
    step();
    bus.i2c_fifo_full = 1'b0;
    wait_idle(500);
    check("t2_writes", 64'(n_writes - base), 64'(1));
    check("t2_pass_cnt", 64'(pass_cnt), 64'(1));

    // Command 2 never answered: timeout then continue to index 3
    resp_delay = 20; base = n_writes; tp0 = n_tp; d0 = n_done;
    skip_at = base + 2;
    for (int i = 0; i < 4; i++) exp_cmd_q.push_back(words[i]);
    do_start(4);
    wait_idle(3000);
    skip_at = -1;
    check("t3_tp_count", 64'(n_tp - tp0), 64'(1));
    check("t3_tp_latency", 64'(tp_cyc - enter_cyc), 64'(T_OUT));
    check("t3_timeout_cnt", 64'(timeout_cnt), 64'(1));
    check("t3_pass_cnt", 64'(pass_cnt), 64'(3));
    check("t3_cmd_idx", 64'(cmd_idx), 64'(3));
    check("t3_done", 64'(n_done - d0), 64'(1));
    check("t3_cmd_q_empty", 64'(exp_cmd_q.size()), 64'(0));

    // Looping over 3 entries, stop after the 7th completion
    resp_delay = 5; r0 = n_resp; d0 = n_done; loop_en = 1'b1;
    for (int i = 0; i < 8; i++) exp_cmd_q.push_back(words[i % 3]);
    do_start(3);
    k = 0;
    while ((n_resp - r0) < 7 && k < 1000) begin @(negedge clk); k++; end
    check("t4_seven_done", 64'(n_resp - r0), 64'(7));
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(500);
    repeat (10) @(negedge clk);
    loop_en = 1'b0;
    check("t4_pass_cnt", 64'(pass_cnt), 64'(8));
    check("t4_resp", 64'(n_resp - r0), 64'(8));
    check("t4_no_done", 64'(n_done - d0), 64'(0));
    check("t4_cmd_idx", 64'(cmd_idx), 64'(1));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_cmd_q_empty", 64'(exp_cmd_q.size()), 64'(0));

    // Response coinciding with timer expiry; table write while busy is dropped
    resp_delay = T_OUT; tp0 = n_tp;
    exp_cmd_q.push_back(words[0]);
    do_start(1);
    repeat (10) step();
    tbl_write(0, 56'hDE_ADBE_EFDE_ADBE);
    wait_idle(3000);
    check("t5_pass_cnt", 64'(pass_cnt), 64'(1));
    check("t5_timeout_cnt", 64'(timeout_cnt), 64'(0));
    check("t5_no_tp", 64'(n_tp - tp0), 64'(0));
    base = n_writes;
    stray_req++;
    repeat (5) step();
    check("t5_stray_pass", 64'(pass_cnt), 64'(1));
    check("t5_stray_busy", 64'(busy), 64'(0));
    check("t5_stray_writes", 64'(n_writes - base), 64'(0));
    resp_delay = 10;
    exp_cmd_q.push_back(words[0]);
    do_start(1);
    wait_idle(500);
    check("t5_readback_q_empty", 64'(exp_cmd_q.size()), 64'(0));

    // Reset while waiting on the second command
    base = n_writes; skip_at = base + 1;
    exp_cmd_q.push_back(words[0]);
    exp_cmd_q.push_back(words[1]);
    do_start(2);
    k = 0;
    while (n_writes < base + 2 && k < 500) begin @(negedge clk); k++; end
    check("t6_writes", 64'(n_writes - base), 64'(2));
    repeat (5) step();
    check("t6_pre_pass", 64'(pass_cnt), 64'(1));
    rstn = 1'b0;
    step();
    @(negedge clk);
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_wr_en", 64'(bus.i2c_fifo_wr_en), 64'(0));
    check("t6_pass_cnt", 64'(pass_cnt), 64'(0));
    check("t6_timeout_cnt", 64'(timeout_cnt), 64'(0));
    check("t6_cmd_idx", 64'(cmd_idx), 64'(0));
    step();
    rstn = 1'b1;
    skip_at = -1;
    base = n_writes;
    do_start(0);
    repeat (5) @(negedge clk);
    check("t6_zero_start_busy", 64'(busy), 64'(0));
    check("t6_zero_start_writes", 64'(n_writes - base), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
